pc_sequencer: RTL and testbench

Program-counter sequencer that consumes the branch/jump target address and owns the architectural PC. It supplies PC and PC+4 to fetch and to the target-address adder, and applies taken branches and jumps. It holds the PC while memory asserts BUSYWAIT, and remembers a redirect that resolves during a stall. It sits between the control unit/ALU flags and the instruction memory in the single-cycle datapath.

---
 rtl/pc_sequencer_if.sv | 42 ++++
 rtl/pc_sequencer.sv | 125 ++++++++++++
 tb/tb_pc_sequencer.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: bundle between the program-counter sequencer and the
// datapath/memory side.
//   master : datapath/memory side; drives BUSYWAIT, TARGET_ADDR, JUMP,
//            BRANCH_EQ, BRANCH_NE, ZERO; observes PC, PC_PLUS4, FETCH_EN,
//            REDIRECT (and TAKEN_COUNT when built with BRANCH_COUNT_EN).
//   slave  : the sequencer itself, the mirror image of master.
// Optional macro: BRANCH_COUNT_EN adds TAKEN_COUNT[15:0].
interface pc_sequencer_if #(
  parameter int PC_WIDTH = 32
);
  logic                BUSYWAIT;
  logic [PC_WIDTH-1:0] TARGET_ADDR;
  logic                JUMP;
  logic                BRANCH_EQ;
  logic                BRANCH_NE;
  logic                ZERO;
  logic [PC_WIDTH-1:0] PC;
  logic [PC_WIDTH-1:0] PC_PLUS4;
  logic                FETCH_EN;
  logic                REDIRECT;
`ifdef BRANCH_COUNT_EN
  logic [15:0]         TAKEN_COUNT;

  modport master (
    output BUSYWAIT, TARGET_ADDR, JUMP, BRANCH_EQ, BRANCH_NE, ZERO,
    input  PC, PC_PLUS4, FETCH_EN, REDIRECT, TAKEN_COUNT
  );
  modport slave (
    input  BUSYWAIT, TARGET_ADDR, JUMP, BRANCH_EQ, BRANCH_NE, ZERO,
    output PC, PC_PLUS4, FETCH_EN, REDIRECT, TAKEN_COUNT
  );
`else
  modport master (
    output BUSYWAIT, TARGET_ADDR, JUMP, BRANCH_EQ, BRANCH_NE, ZERO,
    input  PC, PC_PLUS4, FETCH_EN, REDIRECT
  );
  modport slave (
    input  BUSYWAIT, TARGET_ADDR, JUMP, BRANCH_EQ, BRANCH_NE, ZERO,
    output PC, PC_PLUS4, FETCH_EN, REDIRECT
  );
`endif
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: owns the architectural PC. Advances by PC_INC each cycle,
// loads branch/jump targets, holds while memory stalls and remembers the
// first redirect that resolves during a stall.
// Ports:
//   CLK   - clock, rising edge
//   RESET - asynchronous active-high reset
//   bus   - pc_sequencer_if.slave: BUSYWAIT, TARGET_ADDR, JUMP, BRANCH_EQ,
//           BRANCH_NE, ZERO in; PC, PC_PLUS4, FETCH_EN, REDIRECT out
// Optional macro: BRANCH_COUNT_EN adds a saturating 16-bit count of loaded
// targets on bus.TAKEN_COUNT.
module pc_sequencer #(
  parameter int                PC_WIDTH     = 32,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0,
  parameter int                PC_INC       = 4
) (
  input  logic         CLK,
  input  logic         RESET,
  pc_sequencer_if.slave bus
);

  typedef enum logic [1:0] {S_BOOT, S_RUN, S_STALL} state_t;

  state_t              r_state, w_state_nxt;
  logic [PC_WIDTH-1:0] r_pc, w_pc_nxt;
  logic                r_fetch_en, w_fetch_en_nxt;
  logic                r_redirect, w_redirect_nxt;
  logic                r_pend_valid, w_pend_valid_nxt;
  logic [PC_WIDTH-1:0] r_pend_addr, w_pend_addr_nxt;

  logic                w_take;
  logic [PC_WIDTH-1:0] w_pc_plus4;
  logic [PC_WIDTH-1:0] w_tgt;

  // JUMP combined with a branch is still one redirect to the same target.
  assign w_take     = bus.JUMP | (bus.BRANCH_EQ & bus.ZERO) | (bus.BRANCH_NE & ~bus.ZERO);
  assign w_pc_plus4 = r_pc + PC_WIDTH'(PC_INC);
  // Targets are forced word aligned.
  assign w_tgt      = bus.TARGET_ADDR & ~PC_WIDTH'(3);

  // State register
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) r_state <= S_BOOT;
    else       r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_BOOT:  w_state_nxt = S_RUN;
      S_RUN:   w_state_nxt = bus.BUSYWAIT ? S_STALL : S_RUN;
      S_STALL: w_state_nxt = bus.BUSYWAIT ? S_STALL : S_RUN;
      default: w_state_nxt = S_BOOT;
    endcase
  end

  // Output / datapath next values
  always_comb begin
    w_pc_nxt         = r_pc;
    w_fetch_en_nxt   = 1'b1;
    w_redirect_nxt   = 1'b0;
    w_pend_valid_nxt = r_pend_valid;
    w_pend_addr_nxt  = r_pend_addr;
    case (r_state)
      S_BOOT: ; // control inputs ignored; PC stays at the reset vector
      S_RUN, S_STALL: begin
        if (bus.BUSYWAIT) begin
          // First redirect seen during a stall wins; later ones are dropped.
          if (w_take && !r_pend_valid) begin
            w_pend_valid_nxt = 1'b1;
            w_pend_addr_nxt  = w_tgt;
          end
        end else begin
          if (r_pend_valid) begin
            w_pc_nxt       = r_pend_addr;
            w_redirect_nxt = 1'b1;
          end else if (w_take) begin
            w_pc_nxt       = w_tgt;
            w_redirect_nxt = 1'b1;
          end else begin
            w_pc_nxt       = w_pc_plus4;
          end
          w_pend_valid_nxt = 1'b0;
        end
      end
      default: w_fetch_en_nxt = 1'b0;
    endcase
  end

  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      r_pc         <= RESET_VECTOR;
      r_fetch_en   <= 1'b0;
      r_redirect   <= 1'b0;
      r_pend_valid <= 1'b0;
      r_pend_addr  <= '0;
    end else begin
      r_pc         <= w_pc_nxt;
      r_fetch_en   <= w_fetch_en_nxt;
      r_redirect   <= w_redirect_nxt;
      r_pend_valid <= w_pend_valid_nxt;
      r_pend_addr  <= w_pend_addr_nxt;
    end
  end

  assign bus.PC       = r_pc;
  assign bus.PC_PLUS4 = w_pc_plus4;
  assign bus.FETCH_EN = r_fetch_en;
  assign bus.REDIRECT = r_redirect;

`ifdef BRANCH_COUNT_EN
  logic [15:0] r_taken_cnt;

  // Counts edges that load a target; saturates instead of wrapping.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET)
      r_taken_cnt <= '0;
    else if (w_redirect_nxt && r_taken_cnt != 16'hFFFF)
      r_taken_cnt <= r_taken_cnt + 16'd1;
  end

  assign bus.TAKEN_COUNT = r_taken_cnt;
`endif

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  logic CLK = 1'b0;
  logic RESET = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  pc_sequencer_if #(.PC_WIDTH(32)) bus();

  pc_sequencer #(.PC_WIDTH(32), .RESET_VECTOR(32'h0), .PC_INC(4)) dut (
    .CLK(CLK), .RESET(RESET), .bus(bus)
  );

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got %h want %h @%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: architectural rules only. Since RUN and STALL share the
  // same rule for a given BUSYWAIT value, only "booted" and a pending queue
  // are needed.
  logic [31:0] m_pc;
  logic        m_fetch, m_redir, m_booted;
  logic [31:0] m_pend[$];
  logic [15:0] m_cnt;

  always @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      m_pc = 32'h0; m_fetch = 0; m_redir = 0; m_booted = 0; m_pend.delete(); m_cnt = 0;
    end else if (!m_booted) begin
      m_booted = 1; m_fetch = 1; m_redir = 0;
    end else begin
      logic take;
      logic [31:0] tgt;
      take = bus.JUMP || (bus.BRANCH_EQ && bus.ZERO) || (bus.BRANCH_NE && !bus.ZERO);
      tgt  = {bus.TARGET_ADDR[31:2], 2'b00};
      if (bus.BUSYWAIT) begin
        m_redir = 0;
        if (take && m_pend.size() == 0) m_pend.push_back(tgt);
      end else if (m_pend.size() != 0) begin
        m_pc = m_pend.pop_front(); m_redir = 1;
      end else if (take) begin
        m_pc = tgt; m_redir = 1;
      end else begin
        m_pc = m_pc + 32'd4; m_redir = 0;
      end
      if (m_redir && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge CLK) begin
    chk("m_pc",       bus.PC,       m_pc);
    chk("m_pc_plus4", bus.PC_PLUS4, m_pc + 32'd4);
    chk("m_fetch_en", {31'd0, bus.FETCH_EN}, {31'd0, m_fetch});
    chk("m_redirect", {31'd0, bus.REDIRECT}, {31'd0, m_redir});
`ifdef BRANCH_COUNT_EN
    chk("m_taken_cnt", {16'd0, bus.TAKEN_COUNT}, {16'd0, m_cnt});
`endif
  end

  // Drive one cycle of inputs, then sample just after the edge.
  task automatic step(input logic busy, input logic [31:0] tgt,
                      input logic j, input logic beq, input logic bne, input logic z);
    bus.BUSYWAIT = busy; bus.TARGET_ADDR = tgt;
    bus.JUMP = j; bus.BRANCH_EQ = beq; bus.BRANCH_NE = bne; bus.ZERO = z;
    @(posedge CLK); #1;
  endtask

  int pulses;

  initial begin
    bus.BUSYWAIT = 0; bus.TARGET_ADDR = 0; bus.JUMP = 0;
    bus.BRANCH_EQ = 0; bus.BRANCH_NE = 0; bus.ZERO = 0;
    repeat (2) @(posedge CLK);
    #1;
    chk("rst_pc",       bus.PC, 32'h0);
    chk("rst_pc_plus4", bus.PC_PLUS4, 32'h4);
    chk("rst_fetch",    {31'd0, bus.FETCH_EN}, 32'd0);
    RESET = 0;
    #2 chk("pre_boot_fetch", {31'd0, bus.FETCH_EN}, 32'd0);

    // Boot then sequential fetch
    step(0, 32'h0, 0, 0, 0, 0); chk("boot_pc", bus.PC, 32'h0);
    chk("boot_fetch", {31'd0, bus.FETCH_EN}, 32'd1);
    step(0, 32'h0, 0, 0, 0, 0); chk("seq_4", bus.PC, 32'h4);
    step(0, 32'h0, 0, 0, 0, 0); chk("seq_8", bus.PC, 32'h8);
    step(0, 32'h0, 0, 0, 0, 0); chk("seq_c", bus.PC, 32'hC);
    step(0, 32'h0, 0, 0, 0, 0); chk("seq_10", bus.PC, 32'h10);

    // Branch taken / not taken
    step(0, 32'h40, 0, 1, 0, 1); chk("beq_taken", bus.PC, 32'h40);
    chk("beq_redirect", {31'd0, bus.REDIRECT}, 32'd1);
    step(0, 32'h80, 0, 0, 1, 1); chk("bne_not_taken", bus.PC, 32'h44);
    chk("bne_no_redirect", {31'd0, bus.REDIRECT}, 32'd0);
    step(0, 32'h99, 0, 1, 0, 0); chk("beq_not_taken", bus.PC, 32'h48);

    // Redirect during a 3-cycle stall; first target wins
    step(0, 32'h20, 1, 0, 0, 0); chk("jump_20", bus.PC, 32'h20);
    pulses = 0;
    step(1, 32'h80, 1, 0, 0, 0); chk("stall_hold1", bus.PC, 32'h20); pulses += int'(bus.REDIRECT);
    step(1, 32'h100, 1, 0, 0, 0); chk("stall_hold2", bus.PC, 32'h20); pulses += int'(bus.REDIRECT);
    step(1, 32'h100, 1, 0, 0, 0); chk("stall_hold3", bus.PC, 32'h20); pulses += int'(bus.REDIRECT);
    step(0, 32'h100, 1, 0, 0, 0); chk("stall_release", bus.PC, 32'h80); pulses += int'(bus.REDIRECT);
    step(0, 32'h0, 0, 0, 0, 0); chk("after_stall", bus.PC, 32'h84); pulses += int'(bus.REDIRECT);
    chk("stall_pulses", pulses, 32'd1);

    // Jump and branch together, unaligned target
    step(0, 32'h202, 1, 1, 0, 1); chk("jump_beq", bus.PC, 32'h200);

    // Alignment and wrap
    step(0, 32'hFFFF_FFFE, 1, 0, 0, 0); chk("align_top", bus.PC, 32'hFFFF_FFFC);
    chk("plus4_wrap", bus.PC_PLUS4, 32'h0);
    step(0, 32'h0, 0, 0, 0, 0); chk("wrap_pc", bus.PC, 32'h0);
    step(0, 32'h0, 0, 0, 0, 0); chk("post_wrap", bus.PC, 32'h4);

    // Reset mid-stall with a pending jump
    step(1, 32'h300, 1, 0, 0, 0); chk("pend_hold", bus.PC, 32'h4);
    RESET = 1;
    #1;
    chk("async_rst_pc", bus.PC, 32'h0);
    chk("async_rst_fetch", {31'd0, bus.FETCH_EN}, 32'd0);
    @(posedge CLK); #1;
    RESET = 0;
    step(0, 32'h0, 0, 0, 0, 0); chk("reboot_pc", bus.PC, 32'h0);
    chk("reboot_redirect", {31'd0, bus.REDIRECT}, 32'd0);
    step(0, 32'h0, 0, 0, 0, 0); chk("reboot_seq", bus.PC, 32'h4);
    chk("no_stale_redirect", {31'd0, bus.REDIRECT}, 32'd0);

`ifdef BRANCH_COUNT_EN
    chk("cnt_after_rst", {16'd0, bus.TAKEN_COUNT}, 32'd0);
    step(0, 32'h400, 1, 0, 0, 0);
    step(0, 32'h500, 1, 0, 0, 0);
    step(0, 32'h600, 1, 0, 0, 0);
    chk("cnt_three", {16'd0, bus.TAKEN_COUNT}, 32'd3);
    #2;
    dut.r_taken_cnt = 16'hFFFE;
    m_cnt = 16'hFFFE;
    step(0, 32'h700, 1, 0, 0, 0);
    step(0, 32'h800, 1, 0, 0, 0);
    step(0, 32'h900, 1, 0, 0, 0);
    chk("cnt_saturate", {16'd0, bus.TAKEN_COUNT}, 32'h0000_FFFF);
`endif

    step(0, 32'h0, 0, 0, 0, 0);
    @(negedge CLK); #1;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end
endmodule
